fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage built around the program counter register (pc).
//  - Consumes the pc output as the fetch address and reads instruction ROM over a req/ack handshake.
//  - Buffers fetched words in a small prefetch queue and presents them to the CPU over valid/ready.
//  - Drives the pc's inc/load/in inputs; accepts jump redirects from the CPU and flushes stale words.
// PARAMETERS
//  DEPTH  2   prefetch queue entries (1..4)
//  WIDTH  16  address and instruction width (fixed for Hack, kept as parameter)
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  reset        in   1      synchronous, active-high; shared with pc
//  pc_addr      in   WIDTH  current pc output (fetch address)
//  pc_inc       out  1      pulse: pc advances by 1 at next edge
//  pc_load      out  1      pulse: pc loads pc_in at next edge
//  pc_in        out  WIDTH  jump target to pc (= jump_addr)
//  rom_req      out  1      ROM read request
//  rom_addr     out  WIDTH  ROM read address
//  rom_ack      in   1      ROM data valid; may assert in same cycle as rom_req
//  rom_data     in   WIDTH  ROM read data, sampled when rom_req & rom_ack
//  instr        out  WIDTH  queue head instruction
//  instr_valid  out  1      queue non-empty
//  instr_ready  in   1      CPU consumes head when instr_valid & instr_ready
//  jump         in   1      one-cycle redirect request from CPU
//  jump_addr    in   WIDTH  redirect target
// BEHAVIOUR
//  Reset: while reset=1, pc_inc=pc_load=rom_req=0 combinationally; after the edge: state IDLE, queue empty,
//   instr_valid=0, instr=0, addr_q=0. Reset mid-request abandons it; a late rom_ack is ignored (rom_req=0).
//  FSM states IDLE, WAIT, DRAIN; at most one outstanding ROM request.
//  - IDLE: issue iff count<DEPTH and jump=0: rom_req=1, rom_addr=pc_addr, addr_q<=pc_addr.
//    If rom_ack in the same cycle, complete as below and stay IDLE; otherwise go to WAIT.
//  - WAIT: rom_req=1, rom_addr=addr_q (held stable until ack). On ack -> IDLE.
//  - DRAIN: rom_req=1, rom_addr=addr_q. On ack: discard data, no pc_inc -> IDLE.
//  Completion (ack, not draining, no jump): push rom_data at tail; pc_inc=1 in that same cycle.
//   Zero-wait ROM therefore sustains 1 instr/cycle.
//  Pop: valid & ready removes head. Push and pop in the same cycle leave count unchanged, also when full.
//  Jump (jump=1):
//   - pc_load=1 and pc_in=jump_addr; pc_inc is forced 0.
//   - Queue flushed: count<=0, so instr_valid=0 in the next cycle. A pop in the same cycle is irrelevant; flush wins.
//   - No new issue this cycle; IDLE issues from the new pc_addr one cycle later.
//   - WAIT without ack -> DRAIN. Ack in the jump cycle: data discarded -> IDLE. In DRAIN, remain DRAIN.
//  rom_ack while rom_req=0 is ignored. Outputs pc_inc, pc_load and rom_req are Mealy (same-cycle).
//  pc address wraps 0xFFFF->0x0000 via pc incrementer; fetch_unit imposes no bound.
//  count width = clog2(DEPTH+1); head/tail pointers wrap modulo DEPTH.
// STRUCTURE
//  Shared header src/fetch_defs.vh (`ifndef guarded): FETCH_IDLE=2'd0, FETCH_WAIT=2'd1, FETCH_DRAIN=2'd2.
//  Sub-module fetch_queue (DEPTH x WIDTH sync FIFO, push/pop/flush, count, head out).
//  fetch_unit = FSM + addr_q + handshake glue; top level instantiates fetch_unit beside pc.
// TESTING (bench instantiates pc + fetch_unit + ROM model with programmable ack latency)
//  1. Reset, zero-wait ROM[i]=0x1000+i, ready=1 -> instr 0x1000,0x1001,0x1002 on consecutive cycles; pc=3 after 3 acks.
//  2. ROM latency 3, ready=1 -> rom_req held 4 cycles with rom_addr stable; one pc_inc per ack; 1 instr per 4 cycles.
//  3. ready=0, DEPTH=2 -> exactly 2 acks, then rom_req=0 with count=2; ready=1 -> fetch resumes.
//  4. jump to 0x0040 while in WAIT (latency 3) -> DRAIN discards old word; next instr is ROM[0x0040]; pc=0x0041 after its ack.
//  5. jump in same cycle as ack and pop -> word dropped, instr_valid=0 next cycle, pc=jump_addr, no pc_inc.
//  6. reset asserted in WAIT with late ack -> no push, pc=0, instr_valid=0, first post-reset fetch from 0x0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int FETCH_DEPTH = 2;
  localparam int FETCH_WIDTH = 16;

  // Fetch sequencer states; DRAIN waits out a request made stale by a jump.
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: pc control, ROM read handshake and CPU instruction port.
interface fetch_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pc_addr;
  logic             pc_inc;
  logic             pc_load;
  logic [WIDTH-1:0] pc_in;
  logic             rom_req;
  logic [WIDTH-1:0] rom_addr;
  logic             rom_ack;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             jump;
  logic [WIDTH-1:0] jump_addr;

  // fetch_unit side
  modport master (
    input  pc_addr, rom_ack, rom_data, instr_ready, jump, jump_addr,
    output pc_inc, pc_load, pc_in, rom_req, rom_addr, instr, instr_valid
  );

  // pc / ROM / CPU side
  modport slave (
    output pc_addr, rom_ack, rom_data, instr_ready, jump, jump_addr,
    input  pc_inc, pc_load, pc_in, rom_req, rom_addr, instr, instr_valid
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch queue: DEPTH x WIDTH synchronous FIFO with flush.
// Head reads as zero while empty so the CPU port never shows stale data.
module fetch_unit_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A push into a full queue is accepted only when the head leaves the same cycle.
  assign do_push = push & ~flush & ((count != FULL) | pop);
  assign do_pop  = pop & ~flush & (count != '0);
  assign dout    = (count == '0) ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues ROM reads at the pc address, queues the
// returned words for the CPU and steers the pc (advance on fill, load on jump).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int WIDTH = FETCH_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e     state, state_nxt;
  logic [WIDTH-1:0] addr_q;
  logic [CW-1:0]    count;
  logic             issue, ack, push, pop;

  assign pop             = bus.instr_valid & bus.instr_ready;
  assign bus.instr_valid = (count != '0);

  // Mealy handshake: request, completion and pc control all settle in the
  // same cycle so a zero-wait ROM sustains one instruction per cycle.
  always_comb begin
    issue        = 1'b0;
    ack          = 1'b0;
    push         = 1'b0;
    state_nxt    = state;
    bus.rom_req  = 1'b0;
    bus.rom_addr = addr_q;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.pc_in    = bus.jump_addr;
    if (!reset) begin
      case (state)
        FETCH_IDLE: begin
          // A jump cycle never issues: the pc still holds the old stream.
          if ((count != FULL) && !bus.jump) begin
            issue        = 1'b1;
            bus.rom_req  = 1'b1;
            bus.rom_addr = bus.pc_addr;
          end
        end
        FETCH_WAIT, FETCH_DRAIN: bus.rom_req = 1'b1;
        default: ;
      endcase
      ack         = bus.rom_req & bus.rom_ack;
      push        = ack & (state != FETCH_DRAIN) & ~bus.jump;
      bus.pc_inc  = push;
      bus.pc_load = bus.jump;
      case (state)
        FETCH_IDLE:  if (issue && !ack) state_nxt = FETCH_WAIT;
        FETCH_WAIT:  if (ack) state_nxt = FETCH_IDLE;
                     else if (bus.jump) state_nxt = FETCH_DRAIN;
        FETCH_DRAIN: if (ack) state_nxt = FETCH_IDLE;
        default:     state_nxt = FETCH_IDLE;
      endcase
    end
  end

  // Sequencer state and the address held stable for an outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH_IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (issue) addr_q <= bus.pc_addr;
    end
  end

  fetch_unit_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.rom_data),
    .pop   (pop),
    .flush (bus.jump),
    .dout  (bus.instr),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural pc register, ROM with programmable or
// random ack latency, directed scenarios plus a random run against a
// program-order stream model (consecutive addresses, redirected by jumps).
module tb_fetch_unit;
  localparam int W = 16;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(W)) bus();

  fetch_unit #(.DEPTH(D), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] pc;
  int          lat;
  int          wcnt;
  logic        rnd_mode, rnd_bit, force_ack;
  logic [15:0] rmul, radd;
  int          vectors, miscompares, delivered;
  logic [15:0] exp_addr, prev_addr;
  logic        post_jump, prev_wait;

  // ROM contents as a closed-form function of the address
  function automatic logic [15:0] rom_f(input logic [15:0] a);
    return 16'(a * rmul + radd);
  endfunction

  assign bus.pc_addr  = pc;
  assign bus.rom_ack  = force_ack | (bus.rom_req & (rnd_mode ? rnd_bit : (wcnt >= lat)));
  assign bus.rom_data = rom_f(bus.rom_addr);

  // pc register beside the fetch unit
  always @(posedge clk) begin
    if (reset)            pc <= 16'h0000;
    else if (bus.pc_load) pc <= bus.pc_in;
    else if (bus.pc_inc)  pc <= pc + 16'h0001;
  end

  // ROM wait counter: cycles the current request has been pending
  always @(posedge clk) begin
    if (reset || !bus.rom_req || bus.rom_ack) wcnt <= 0;
    else                                      wcnt <= wcnt + 1;
  end

  // Stream monitor: every consumed word must be the next program-order word
  always @(negedge clk) begin
    if (reset) begin
      exp_addr  = 16'h0000;
      post_jump = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (post_jump) begin
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL flush: instr_valid=%b after jump, want 0", bus.instr_valid);
        end
      end
      if (prev_wait) begin
        vectors++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== prev_addr) begin
          miscompares++;
          $display("FAIL addr_hold: req=%b addr=%h, want req=1 addr=%h", bus.rom_req, bus.rom_addr, prev_addr);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        vectors++;
        if (bus.instr !== rom_f(exp_addr)) begin
          miscompares++;
          $display("FAIL stream: instr=%h, want %h (addr %h)", bus.instr, rom_f(exp_addr), exp_addr);
        end
        exp_addr = exp_addr + 16'h0001;
        delivered++;
      end
      vectors++;
      if (bus.jump === 1'b1) begin
        if (bus.pc_load !== 1'b1 || bus.pc_inc !== 1'b0 || bus.pc_in !== bus.jump_addr) begin
          miscompares++;
          $display("FAIL jump_ctl: load=%b inc=%b in=%h, want 1 0 %h", bus.pc_load, bus.pc_inc, bus.pc_in, bus.jump_addr);
        end
        exp_addr = bus.jump_addr;
      end else if (bus.pc_load !== 1'b0) begin
        miscompares++;
        $display("FAIL pc_load: got %b without jump, want 0", bus.pc_load);
      end
      post_jump = bus.jump;
      prev_wait = bus.rom_req & ~bus.rom_ack;
      prev_addr = bus.rom_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into the first post-reset cycle
  task automatic do_reset(input int l, input logic [15:0] m, input logic [15:0] a);
    reset = 1'b1;
    bus.jump = 1'b0;
    bus.instr_ready = 1'b0;
    force_ack = 1'b0;
    rnd_mode = 1'b0;
    lat = l;
    rmul = m;
    radd = a;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 16'h1234;
    bus.instr_ready = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.pc_inc, bus.pc_load, bus.rom_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mealy: inc/load/req=%b, want 000", {bus.pc_inc, bus.pc_load, bus.rom_req});
    end
    tick();
    bus.jump = 1'b0;
    force_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.instr_valid, bus.instr, pc} !== {1'b0, 16'h0000, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h, want 0 0000 0000", bus.instr_valid, bus.instr, pc);
    end
  endtask

  task automatic test_zero_wait;
    logic [15:0] e;
    do_reset(0, 16'h0001, 16'h1000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.pc_inc, bus.instr_valid, bus.rom_addr} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL zw_first: req=%b inc=%b valid=%b addr=%h, want 1 1 0 0000",
               bus.rom_req, bus.pc_inc, bus.instr_valid, bus.rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      e = 16'h1000 + 16'(i);
      vectors++;
      if ({bus.instr_valid, bus.instr} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL zw_instr%0d: valid=%b instr=%h, want 1 %h", i, bus.instr_valid, bus.instr, e);
      end
    end
    vectors++;
    if (pc !== 16'h0003) begin
      miscompares++;
      $display("FAIL zw_pc: pc=%h, want 0003", pc);
    end
  endtask

  task automatic test_latency;
    logic e_inc;
    int   n;
    do_reset(3, 16'h0001, 16'h1000);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e_inc = (i == 3);
      vectors++;
      if ({bus.rom_req, bus.pc_inc, bus.rom_addr} !== {1'b1, e_inc, 16'h0000}) begin
        miscompares++;
        $display("FAIL lat_hold%0d: req=%b inc=%b addr=%h, want 1 %b 0000", i, bus.rom_req, bus.pc_inc, bus.rom_addr, e_inc);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if ({bus.instr_valid, bus.instr, bus.rom_addr} !== {1'b1, 16'h1000, 16'h0001}) begin
      miscompares++;
      $display("FAIL lat_deliver: valid=%b instr=%h addr=%h, want 1 1000 0001", bus.instr_valid, bus.instr, bus.rom_addr);
    end
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (bus.instr_valid) n++;
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL lat_rate: %0d instrs in 12 cycles, want 3", n);
    end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset(0, 16'h0001, 16'h1000);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rom_req && bus.rom_ack) n++;
      tick();
    end
    @(negedge clk);
    vectors++;
    if (n != 2 || {bus.rom_req, bus.instr_valid, bus.instr} !== {1'b0, 1'b1, 16'h1000}) begin
      miscompares++;
      $display("FAIL bp_full: acks=%0d req=%b valid=%b instr=%h, want 2 0 1 1000", n, bus.rom_req, bus.instr_valid, bus.instr);
    end
    tick();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.instr_valid, bus.instr} !== {1'b0, 1'b1, 16'h1000}) begin
      miscompares++;
      $display("FAIL bp_pop: req=%b valid=%b instr=%h, want 0 1 1000", bus.rom_req, bus.instr_valid, bus.instr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.rom_addr, bus.instr} !== {1'b1, 16'h0002, 16'h1001}) begin
      miscompares++;
      $display("FAIL bp_resume: req=%b addr=%h instr=%h, want 1 0002 1001", bus.rom_req, bus.rom_addr, bus.instr);
    end
  endtask

  task automatic test_jump_wait;
    bit seen;
    do_reset(3, 16'h0001, 16'h1000);
    bus.instr_ready = 1'b1;
    tick();
    bus.jump = 1'b1;
    bus.jump_addr = 16'h0040;
    @(negedge clk);
    vectors++;
    if ({bus.pc_load, bus.pc_inc, bus.pc_in} !== {1'b1, 1'b0, 16'h0040}) begin
      miscompares++;
      $display("FAIL jw_jump: load=%b inc=%b in=%h, want 1 0 0040", bus.pc_load, bus.pc_inc, bus.pc_in);
    end
    tick();
    bus.jump = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if ({bus.rom_ack, bus.pc_inc, pc} !== {1'b1, 1'b0, 16'h0040}) begin
      miscompares++;
      $display("FAIL jw_drain: ack=%b inc=%b pc=%h, want 1 0 0040", bus.rom_ack, bus.pc_inc, pc);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.rom_addr} !== {1'b1, 16'h0040}) begin
      miscompares++;
      $display("FAIL jw_reissue: req=%b addr=%h, want 1 0040", bus.rom_req, bus.rom_addr);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (bus.instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || bus.instr !== 16'h1040 || pc !== 16'h0041) begin
      miscompares++;
      $display("FAIL jw_target: seen=%b instr=%h pc=%h, want 1 1040 0041", seen, bus.instr, pc);
    end
  endtask

  task automatic test_jump_ack_pop;
    bit seen;
    do_reset(1, 16'h0001, 16'h1000);
    tick();
    tick();
    tick();
    bus.instr_ready = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 16'h0123;
    @(negedge clk);
    vectors++;
    if ({bus.instr_valid, bus.instr, bus.rom_req, bus.rom_ack, bus.pc_inc, bus.pc_load}
        !== {1'b1, 16'h1000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL jap_cycle: valid=%b instr=%h req=%b ack=%b inc=%b load=%b, want 1 1000 1 1 0 1",
               bus.instr_valid, bus.instr, bus.rom_req, bus.rom_ack, bus.pc_inc, bus.pc_load);
    end
    tick();
    bus.jump = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.instr_valid, pc} !== {1'b0, 16'h0123}) begin
      miscompares++;
      $display("FAIL jap_after: valid=%b pc=%h, want 0 0123", bus.instr_valid, pc);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (bus.instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || bus.instr !== 16'h1123) begin
      miscompares++;
      $display("FAIL jap_target: seen=%b instr=%h, want 1 1123", seen, bus.instr);
    end
  endtask

  task automatic test_reset_wait;
    bit seen;
    do_reset(3, 16'h0001, 16'h1000);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.rom_addr, pc} !== {1'b1, 16'h0002, 16'h0002}) begin
      miscompares++;
      $display("FAIL rw_wait: req=%b addr=%h pc=%h, want 1 0002 0002", bus.rom_req, bus.rom_addr, pc);
    end
    tick();
    reset = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rom_req, bus.pc_inc} !== 2'b00) begin
      miscompares++;
      $display("FAIL rw_late_ack: req=%b inc=%b, want 0 0", bus.rom_req, bus.pc_inc);
    end
    tick();
    reset = 1'b0;
    force_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.instr_valid, pc, bus.rom_req, bus.rom_addr} !== {1'b0, 16'h0000, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL rw_restart: valid=%b pc=%h req=%b addr=%h, want 0 0000 1 0000",
               bus.instr_valid, pc, bus.rom_req, bus.rom_addr);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (bus.instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || bus.instr !== 16'h1000) begin
      miscompares++;
      $display("FAIL rw_first: seen=%b instr=%h, want 1 1000", seen, bus.instr);
    end
  endtask

  task automatic test_random;
    int base;
    do_reset(0, 16'($urandom) | 16'h0001, 16'($urandom));
    rnd_mode = 1'b1;
    base = delivered;
    for (int i = 0; i < 3000; i++) begin
      rnd_bit = 1'($urandom);
      bus.instr_ready = ($urandom % 4) != 0;
      bus.jump = ($urandom % 16) == 0;
      bus.jump_addr = (($urandom % 4) == 0) ? 16'hFFFE : 16'($urandom);
      tick();
    end
    bus.jump = 1'b0;
    rnd_mode = 1'b0;
    @(negedge clk);
    vectors++;
    if (delivered - base < 300) begin
      miscompares++;
      $display("FAIL rnd_progress: %0d instrs delivered, want at least 300", delivered - base);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    delivered = 0;
    lat = 0;
    rmul = 16'h0001;
    radd = 16'h1000;
    rnd_mode = 1'b0;
    rnd_bit = 1'b0;
    force_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = 16'h0000;
    test_reset();
    test_zero_wait();
    test_latency();
    test_backpressure();
    test_jump_wait();
    test_jump_ack_pop();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
